// File: rtl/bsg_link_pkg.sv
// Shared types and sizing helpers for the multi-channel SDR link sender and its
// credit/token companions.
package bsg_link_pkg;

  typedef enum logic {
    eIdle = 1'b0,
    eSend = 1'b1
  } link_state_e;

  // One extra bit so the full-FIFO count 2^lg_depth is representable.
  function automatic int credit_width(input int lg_depth);
    return lg_depth + 1;
  endfunction

  function automatic int beats_for(input int width, input int beat_width);
    return (width + beat_width - 1) / beat_width;
  endfunction

  function automatic int beat_cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/bsg_link_credit_counter.sv
// Saturating up/down credit counter: +incr_p per inc pulse, -1 per dec pulse,
// clamps at max_p and latches a sticky overflow flag when it would exceed it.
module bsg_link_credit_counter #(
  parameter int width_p = 4,
  parameter int max_p   = 8,
  parameter int incr_p  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dec,
  input  logic               inc,
  output logic [width_p-1:0] count,
  output logic               overflow
);

  logic [width_p-1:0] count_r;
  logic               overflow_r;
  logic [width_p:0]   sum;

  // One guard bit so count + incr_p cannot wrap before the saturation test.
  always_comb begin
    sum = {1'b0, count_r};
    if (inc) sum = sum + (width_p+1)'(incr_p);
    if (dec) sum = sum - (width_p+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r    <= width_p'(max_p);
      overflow_r <= 1'b0;
    end else if (sum > (width_p+1)'(max_p)) begin
      count_r    <= width_p'(max_p);
      overflow_r <= 1'b1;
    end else begin
      count_r <= sum[width_p-1:0];
    end
  end

  assign count    = count_r;
  assign overflow = overflow_r;

endmodule

// File: rtl/bsg_link_sdr_upstream_mc.sv
// Multi-channel SDR upstream sender: serialises core words LSB-first over
// num_channels_p channels, one registered beat per cycle, under credit flow control.
module bsg_link_sdr_upstream_mc
  import bsg_link_pkg::*;
#(
  parameter int width_p                         = 32,
  parameter int num_channels_p                  = 2,
  parameter int channel_width_p                 = 8,
  parameter int lg_fifo_depth_p                 = 6,
  parameter int lg_credit_to_token_decimation_p = 3
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic                                      link_enable_i,
  input  logic [width_p-1:0]                        data_i,
  input  logic                                      valid_i,
  output logic                                      ready_o,
  output logic [num_channels_p*channel_width_p-1:0] io_data_r_o,
  output logic                                      io_valid_r_o,
  input  logic                                      io_token_i,
  output logic [lg_fifo_depth_p:0]                  credit_avail_o,
  output logic                                      credit_err_o
);

  localparam int beat_width_lp   = num_channels_p * channel_width_p;
  localparam int beats_lp        = beats_for(width_p, beat_width_lp);
  localparam int cnt_width_lp    = beat_cnt_width(beats_lp);
  localparam int pad_width_lp    = beats_lp * beat_width_lp;
  localparam int credit_width_lp = credit_width(lg_fifo_depth_p);

  link_state_e                state_r;
  logic [cnt_width_lp-1:0]    beat_r;
  logic [pad_width_lp-1:0]    shift_r;
  logic [beat_width_lp-1:0]   data_r;
  logic                       valid_r;
  logic [pad_width_lp-1:0]    padded;
  logic [credit_width_lp-1:0] credit;
  logic                       credit_err;
  logic                       last_beat;
  logic                       accept;

  always_comb begin
    padded                = '0;
    padded[width_p-1:0]   = data_i;
  end

  assign last_beat = (state_r == eSend) && (beat_r == cnt_width_lp'(beats_lp - 1));

  // Gated by reset_i so the core never sees ready while the link is held in reset.
  assign ready_o = reset_i & link_enable_i & (credit != '0)
                 & ((state_r == eIdle) | last_beat);
  assign accept  = valid_i & ready_o;

  // Accept loads beat 0 directly onto the output; shift_r keeps the remaining beats.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r <= eIdle;
      beat_r  <= '0;
      shift_r <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
    end else if (accept) begin
      state_r <= eSend;
      beat_r  <= '0;
      data_r  <= padded[beat_width_lp-1:0];
      shift_r <= padded >> beat_width_lp;
      valid_r <= 1'b1;
    end else if ((state_r == eSend) && !last_beat) begin
      beat_r  <= beat_r + cnt_width_lp'(1);
      data_r  <= shift_r[beat_width_lp-1:0];
      shift_r <= shift_r >> beat_width_lp;
      valid_r <= 1'b1;
    end else begin
      state_r <= eIdle;
      valid_r <= 1'b0;
    end
  end

  bsg_link_credit_counter #(
    .width_p (credit_width_lp),
    .max_p   (1 << lg_fifo_depth_p),
    .incr_p  (1 << lg_credit_to_token_decimation_p)
  ) credit_counter (
    .clk      (clk_i),
    .rst_n    (reset_i),
    .dec      (accept),
    .inc      (io_token_i),
    .count    (credit),
    .overflow (credit_err)
  );

  assign io_data_r_o    = data_r;
  assign io_valid_r_o   = valid_r;
  assign credit_avail_o = credit;
  assign credit_err_o   = credit_err;

endmodule

// File: tb/tb_bsg_link_sdr_upstream_mc.sv
// Bench for bsg_link_sdr_upstream_mc: 32-bit words over 2x8-bit channels, 8 credits,
// 2 credits per token; beats are scoreboarded against words seen accepted.
module tb_bsg_link_sdr_upstream_mc;

  localparam int W   = 32;
  localparam int NC  = 2;
  localparam int CW  = 8;
  localparam int LGF = 3;
  localparam int LGD = 1;
  localparam int BW  = NC * CW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          link_enable_i;
  logic [W-1:0]  data_i;
  logic          valid_i;
  logic          ready_o;
  logic [BW-1:0] io_data_r_o;
  logic          io_valid_r_o;
  logic          io_token_i;
  logic [LGF:0]  credit_avail_o;
  logic          credit_err_o;

  bsg_link_sdr_upstream_mc #(
    .width_p                         (W),
    .num_channels_p                  (NC),
    .channel_width_p                 (CW),
    .lg_fifo_depth_p                 (LGF),
    .lg_credit_to_token_decimation_p (LGD)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .link_enable_i  (link_enable_i),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .io_data_r_o    (io_data_r_o),
    .io_valid_r_o   (io_valid_r_o),
    .io_token_i     (io_token_i),
    .credit_avail_o (credit_avail_o),
    .credit_err_o   (credit_err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  logic [BW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: beats produced by the previous edge are compared first, then any
  // word the DUT accepts at the coming edge is split into its expected beats.
  always @(negedge clk) begin
    if (reset_i) begin
      if (io_valid_r_o) begin
        check_val("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) check_val("sb_beat", io_data_r_o, exp_q.pop_front());
      end
      if (valid_i && ready_o) begin
        for (int b = 0; b < W / BW; b++) exp_q.push_back(data_i[b*BW +: BW]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int n_acc, n_beats, first, last;
  logic acc;

  initial begin
    reset_i       = 1'b0;
    link_enable_i = 1'b1;
    valid_i       = 1'b0;
    data_i        = '0;
    io_token_i    = 1'b0;
    repeat (2) tick();
    check_val("rst_valid",  io_valid_r_o,   0);
    check_val("rst_data",   io_data_r_o,    0);
    check_val("rst_credit", credit_avail_o, 8);
    check_val("rst_err",    credit_err_o,   0);
    check_val("rst_ready",  ready_o,        0);
    reset_i = 1'b1;
    tick();

    // Serialisation of one word
    data_i  = 32'hDDCCBBAA;
    valid_i = 1'b1;
    #1 check_val("ser_ready", ready_o, 1);
    tick();
    valid_i = 1'b0;
    check_val("ser_v0",     io_valid_r_o,   1);
    check_val("ser_beat0",  io_data_r_o,    16'hBBAA);
    check_val("ser_credit", credit_avail_o, 7);
    tick();
    check_val("ser_v1",    io_valid_r_o, 1);
    check_val("ser_beat1", io_data_r_o,  16'hDDCC);
    tick();
    check_val("ser_v2",   io_valid_r_o, 0);
    check_val("ser_hold", io_data_r_o,  16'hDDCC);

    reset_i = 1'b0;
    tick();
    reset_i = 1'b1;
    tick();
    check_val("rst2_credit", credit_avail_o, 8);

    // Credit exhaustion with valid held high
    n_acc = 0; n_beats = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      valid_i = 1'b1;
      data_i  = {8'(n_acc), 8'hA5, 8'(n_acc + 1), 8'h5A};
      #1 acc = ready_o;
      tick();
      if (acc) n_acc++;
      if (io_valid_r_o) begin
        n_beats++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    check_val("exh_words",  n_acc,   8);
    check_val("exh_beats",  n_beats, 16);
    check_val("exh_span",   last - first + 1, 16);
    check_val("exh_ready",  ready_o, 0);
    check_val("exh_credit", credit_avail_o, 0);

    // Token return from zero credits
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    check_val("tok_credit", credit_avail_o, 2);
    check_val("tok_ready",  ready_o, 1);
    n_acc = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      data_i = {8'hC0 + 8'(n_acc), 8'h11, 8'h22, 8'(n_acc)};
      #1 acc = ready_o;
      tick();
      if (acc) n_acc++;
    end
    valid_i = 1'b0;
    check_val("tok_words",  n_acc, 2);
    check_val("tok_credit0", credit_avail_o, 0);
    repeat (3) tick();

    // Simultaneous accept and token at credit 1
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    check_val("sim_credit2", credit_avail_o, 2);
    valid_i = 1'b1;
    data_i  = 32'h12345678;
    tick();
    valid_i = 1'b0;
    check_val("sim_credit1", credit_avail_o, 1);
    tick();
    valid_i    = 1'b1;
    data_i     = 32'h9ABCDEF0;
    io_token_i = 1'b1;
    #1 check_val("sim_ready_last", ready_o, 1);
    tick();
    valid_i    = 1'b0;
    io_token_i = 1'b0;
    check_val("sim_credit", credit_avail_o, 2);
    check_val("sim_err",    credit_err_o,   0);
    repeat (3) tick();

    // Overflow: fill to 8, spend one, then two tokens
    for (int t = 0; t < 3; t++) begin
      io_token_i = 1'b1;
      tick();
      io_token_i = 1'b0;
      tick();
    end
    check_val("ovf_full",   credit_avail_o, 8);
    check_val("ovf_noerr",  credit_err_o,   0);
    valid_i = 1'b1;
    data_i  = 32'hFEEDFACE;
    tick();
    valid_i = 1'b0;
    repeat (2) tick();
    check_val("ovf_credit7", credit_avail_o, 7);
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    check_val("ovf_sat1", credit_avail_o, 8);
    check_val("ovf_err1", credit_err_o,   1);
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
    check_val("ovf_sat2", credit_avail_o, 8);
    repeat (4) tick();
    check_val("ovf_sticky", credit_err_o, 1);

    // link_enable_i dropped on beat 0
    valid_i = 1'b1;
    data_i  = 32'hCAFEF00D;
    tick();
    link_enable_i = 1'b0;
    data_i        = 32'h0BADBEEF;
    tick();
    check_val("dis_beat1_v", io_valid_r_o, 1);
    check_val("dis_beat1",   io_data_r_o,  16'hCAFE);
    check_val("dis_ready",   ready_o,      0);
    tick();
    check_val("dis_idle",   io_valid_r_o,   0);
    check_val("dis_credit", credit_avail_o, 7);
    valid_i       = 1'b0;
    link_enable_i = 1'b1;
    tick();

    // Reset in the middle of a word
    valid_i = 1'b1;
    data_i  = 32'h11223344;
    tick();
    valid_i = 1'b0;
    check_val("mid_v", io_valid_r_o, 1);
    reset_i = 1'b0;
    exp_q.delete();
    #1;
    check_val("mid_rst_valid",  io_valid_r_o,   0);
    check_val("mid_rst_credit", credit_avail_o, 8);
    check_val("mid_rst_err",    credit_err_o,   0);
    check_val("mid_rst_ready",  ready_o,        0);
    tick();
    reset_i = 1'b1;
    tick();

    valid_i = 1'b1;
    data_i  = 32'h55667788;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    check_val("post_credit", credit_avail_o, 7);
    check_val("sb_drain",    exp_q.size(),   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
